manchester_rx: RTL and testbench

Receive-side counterpart of the SWIPT data path.
- Slices the 12-bit ADC current samples against a reference level (`mean_def`) with hysteresis to recover the load-modulated chip stream.
- Aligns to the Manchester chip boundaries and decodes one frame: a start bit followed by N_BITS data bits. Chip pair 01 = 1, 10 = 0.
- Presents the decoded word with a one-cycle valid pulse.
- Sits between the ADC input and the data/control logic that consumes received words.

---
 rtl/swipt_pkg.sv | 16 +
 rtl/level_slicer.sv | 51 +++++
 rtl/manchester_rx.sv | 166 ++++++++++++++++
 tb/tb_manchester_rx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/swipt_pkg.sv
// Shared types and constants for the SWIPT Manchester receive path.
package swipt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    RECV = 2'd2
  } state_t;

  localparam logic [1:0] CHIP_ONE  = 2'b01;
  localparam logic [1:0] CHIP_ZERO = 2'b10;

  localparam int ADC_W_DEF    = 12;
  localparam int CHIP_CYC_DEF = 50;

endpackage

// File: rtl/level_slicer.sv
// Hysteresis comparator turning ADC current samples into a registered chip
// level, plus the delayed copy used for edge detection.
module level_slicer
  import swipt_pkg::*;
#(
  parameter int ADC_W = ADC_W_DEF,
  parameter int HYST  = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [ADC_W-1:0] i_adc,
  input  logic [ADC_W-1:0] i_mean,
  output logic             o_lvl,
  output logic             o_edge,
  output logic             o_rise
);

  localparam logic [ADC_W:0] HYST_X = (ADC_W+1)'(HYST);

  logic [ADC_W:0]   w_hi_ext;
  logic [ADC_W:0]   w_lo_ext;
  logic [ADC_W-1:0] w_hi;
  logic [ADC_W-1:0] w_lo;
  logic             r_lvl;
  logic             r_lvl_d;

  // The extra top bit is the carry/borrow; it selects the saturated value.
  assign w_hi_ext = {1'b0, i_mean} + HYST_X;
  assign w_lo_ext = {1'b0, i_mean} - HYST_X;
  assign w_hi     = w_hi_ext[ADC_W] ? {ADC_W{1'b1}} : w_hi_ext[ADC_W-1:0];
  assign w_lo     = w_lo_ext[ADC_W] ? '0 : w_lo_ext[ADC_W-1:0];

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_lvl   <= 1'b0;
      r_lvl_d <= 1'b0;
    end else begin
      if (i_adc > w_hi) begin
        r_lvl <= 1'b1;
      end else if (i_adc < w_lo) begin
        r_lvl <= 1'b0;
      end
      r_lvl_d <= r_lvl;
    end
  end

  assign o_lvl  = r_lvl;
  assign o_edge = r_lvl ^ r_lvl_d;
  assign o_rise = r_lvl & ~r_lvl_d;

endmodule

// File: rtl/manchester_rx.sv
// Manchester frame receiver: slices ADC samples, locks onto the start bit,
// resyncs on every chip edge and decodes N_BITS data bits MSB-first.
module manchester_rx
  import swipt_pkg::*;
#(
  parameter int ADC_W    = ADC_W_DEF,
  parameter int N_BITS   = 16,
  parameter int CHIP_CYC = CHIP_CYC_DEF,
  parameter int HYST     = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              enable,
  input  logic [ADC_W-1:0]  adc_in,
  input  logic [ADC_W-1:0]  mean_def,
  output logic [N_BITS-1:0] data_out,
  output logic              data_valid,
  output logic              code_err,
  output logic              busy
);

  localparam int QW = $clog2(CHIP_CYC + 1);
  localparam int CW = $clog2(CHIP_CYC);
  localparam int IW = $clog2(2 * N_BITS + 1);

  localparam logic [QW-1:0] QUIET_MAX  = QW'(CHIP_CYC);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CHIP_CYC - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(CHIP_CYC / 2);
  localparam logic [IW-1:0] IDX_LAST   = IW'(2 * N_BITS);

  logic w_lvl;
  logic w_edge;
  logic w_rise;
  logic w_sample;
  logic [1:0] w_pair;

  state_t            r_state,    state_next;
  logic [QW-1:0]     r_quiet,    quiet_next;
  logic [CW-1:0]     r_cnt,      cnt_next;
  logic [IW-1:0]     r_chip_idx, idx_next;
  logic              r_c0,       c0_next;
  logic [N_BITS-1:0] r_shift,    shift_next;
  logic [N_BITS-1:0] r_data,     data_next;
  logic              r_valid,    valid_next;
  logic              r_err,      err_next;

  level_slicer #(
    .ADC_W (ADC_W),
    .HYST  (HYST)
  ) u_slicer (
    .clk    (clk),
    .nrst   (nrst),
    .i_adc  (adc_in),
    .i_mean (mean_def),
    .o_lvl  (w_lvl),
    .o_edge (w_edge),
    .o_rise (w_rise)
  );

  // An edge restarts the chip timer, so it takes precedence over sampling.
  assign w_sample = (r_cnt == CNT_SAMPLE) && !w_edge;
  assign w_pair   = {r_c0, w_lvl};

  always_comb begin
    state_next = r_state;
    quiet_next = r_quiet;
    cnt_next   = r_cnt;
    idx_next   = r_chip_idx;
    c0_next    = r_c0;
    shift_next = r_shift;
    data_next  = r_data;
    valid_next = 1'b0;
    err_next   = 1'b0;

    if (!enable) begin
      state_next = IDLE;
      quiet_next = '0;
      cnt_next   = '0;
      idx_next   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          state_next = HUNT;
          quiet_next = '0;
        end
        HUNT: begin
          if (w_lvl) begin
            quiet_next = '0;
          end else if (r_quiet != QUIET_MAX) begin
            quiet_next = r_quiet + 1'b1;
          end
          if (w_rise && (r_quiet == QUIET_MAX)) begin
            state_next = RECV;
            cnt_next   = '0;
            idx_next   = '0;
          end
        end
        RECV: begin
          if (w_edge || (r_cnt == CNT_LAST)) begin
            cnt_next = '0;
          end else begin
            cnt_next = r_cnt + 1'b1;
          end
          if (w_sample) begin
            idx_next = r_chip_idx + 1'b1;
            if (r_chip_idx == '0) begin
              // Second half of the start bit must be high.
              if (!w_lvl) begin
                err_next   = 1'b1;
                state_next = HUNT;
                quiet_next = '0;
              end
            end else if (r_chip_idx[0]) begin
              c0_next = w_lvl;
            end else if ((w_pair == CHIP_ONE) || (w_pair == CHIP_ZERO)) begin
              shift_next = {r_shift[N_BITS-2:0], (w_pair == CHIP_ONE)};
              if (r_chip_idx == IDX_LAST) begin
                data_next  = shift_next;
                valid_next = 1'b1;
                state_next = HUNT;
                quiet_next = '0;
              end
            end else begin
              err_next   = 1'b1;
              state_next = HUNT;
              quiet_next = '0;
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state    <= IDLE;
      r_quiet    <= '0;
      r_cnt      <= '0;
      r_chip_idx <= '0;
      r_c0       <= 1'b0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= state_next;
      r_quiet    <= quiet_next;
      r_cnt      <= cnt_next;
      r_chip_idx <= idx_next;
      r_c0       <= c0_next;
      r_shift    <= shift_next;
      r_data     <= data_next;
      r_valid    <= valid_next;
      r_err      <= err_next;
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign code_err   = r_err;
  assign busy       = (r_state == RECV);

endmodule

// File: tb/tb_manchester_rx.sv
// Self-checking bench for manchester_rx: slicer vector table plus frame-level
// sequences scored against a queue of expected receive events.
module tb_manchester_rx;

  localparam int CC = 8;
  localparam int NB = 16;
  localparam logic [11:0] LO = 12'h700;
  localparam logic [11:0] HI = 12'h900;

  logic          clk = 1'b0;
  logic          nrst;
  logic          enable;
  logic [11:0]   adc_in;
  logic [11:0]   mean_def;
  logic [NB-1:0] data_out;
  logic          data_valid;
  logic          code_err;
  logic          busy;

  manchester_rx #(
    .ADC_W    (12),
    .N_BITS   (NB),
    .CHIP_CYC (CC),
    .HYST     (16)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .enable     (enable),
    .adc_in     (adc_in),
    .mean_def   (mean_def),
    .data_out   (data_out),
    .data_valid (data_valid),
    .code_err   (code_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          err;
    logic [NB-1:0] data;
    int            at;
  } ev_t;

  typedef struct {
    logic [11:0] mean;
    logic [11:0] adc;
    logic        lvl;
  } vec_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  bit  prev_v = 1'b0;
  bit  prev_e = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every wait goes through here so received events are scored as they appear.
  task automatic step();
    ev_t e;
    @(negedge clk);
    if (prev_v) check("valid_width", 32'(data_valid), 0);
    if (prev_e) check("err_width", 32'(code_err), 0);
    if (data_valid || code_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'b0, code_err, data_valid}, 0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", {30'b0, code_err, data_valid}, e.err ? 2 : 1);
        check("event_data", 32'(data_out), 32'(e.data));
        if (e.at >= 0) check("event_cycle", cyc, e.at);
        $display("event at cycle %0d: valid=%0b err=%0b data_out=%04h", cyc, data_valid, code_err, data_out);
      end
    end
    prev_v = data_valid;
    prev_e = code_err;
  endtask

  task automatic hold(input logic [11:0] v, input int n);
    adc_in = v;
    repeat (n) step();
  endtask

  // Chip k of a frame: 0 = start low, 1 = start high, then two chips per bit.
  task automatic send_frame(input logic [NB-1:0] w, input int pre_low, input bit jit,
                            input int n_chips, input int bad_bit);
    logic ch [2*NB+2];
    ch[0] = 1'b0;
    ch[1] = 1'b1;
    for (int b = 0; b < NB; b++) begin
      ch[2+2*b] = ~w[NB-1-b];
      ch[3+2*b] = w[NB-1-b];
      if (b == bad_bit) begin
        ch[2+2*b] = 1'b1;
        ch[3+2*b] = 1'b1;
      end
    end
    if (pre_low > 0) hold(LO, pre_low);
    for (int k = 0; k < n_chips; k++) begin
      hold(ch[k] ? HI : LO, jit ? (((k % 2) == 0) ? CC + 2 : CC - 2) : CC);
    end
  endtask

  // Cycle at which the event for a sample taken in chip `chip` becomes visible.
  function automatic int ev_at(input int t0, input int pre_low, input int chip);
    return t0 + pre_low + chip * CC + CC / 2 + 3;
  endfunction

  task automatic drain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    vec_t vt [15];
    int   t0;

    vt[0]  = '{12'h800, 12'h900, 1'b1};
    vt[1]  = '{12'h800, 12'h7F8, 1'b1};
    vt[2]  = '{12'h800, 12'h7F0, 1'b1};
    vt[3]  = '{12'h800, 12'h7EF, 1'b0};
    vt[4]  = '{12'h800, 12'h808, 1'b0};
    vt[5]  = '{12'h800, 12'h810, 1'b0};
    vt[6]  = '{12'h800, 12'h811, 1'b1};
    vt[7]  = '{12'h005, 12'h000, 1'b1};
    vt[8]  = '{12'h005, 12'h015, 1'b1};
    vt[9]  = '{12'h800, 12'h700, 1'b0};
    vt[10] = '{12'h005, 12'h016, 1'b1};
    vt[11] = '{12'hFFA, 12'hFE9, 1'b0};
    vt[12] = '{12'hFFA, 12'hFFF, 1'b0};
    vt[13] = '{12'hFFA, 12'hFEA, 1'b0};
    vt[14] = '{12'h800, 12'h7F8, 1'b0};

    nrst     = 1'b1;
    enable   = 1'b0;
    adc_in   = LO;
    mean_def = 12'h800;
    @(negedge clk);
    repeat (3) step();
    check("reset_data_out", 32'(data_out), 0);
    check("reset_data_valid", 32'(data_valid), 0);
    check("reset_code_err", 32'(code_err), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_lvl", 32'(dut.w_lvl), 0);
    nrst = 1'b0;
    step();

    // Slicer thresholds, hysteresis hold and saturation.
    for (int i = 0; i < 15; i++) begin
      mean_def = vt[i].mean;
      adc_in   = vt[i].adc;
      step();
      step();
      $display("vec %0d: mean=%03h adc=%03h lvl=%0b exp=%0b", i, vt[i].mean, vt[i].adc, dut.w_lvl, vt[i].lvl);
      check("slicer_lvl", 32'(dut.w_lvl), 32'(vt[i].lvl));
    end

    // In-band noise must neither move lvl nor start a frame.
    mean_def = 12'h800;
    enable   = 1'b1;
    for (int i = 0; i < 24; i++) begin
      adc_in = ((i % 2) == 1) ? 12'h808 : 12'h7F8;
      step();
      check("noise_lvl", 32'(dut.w_lvl), 0);
      check("noise_busy", 32'(busy), 0);
    end

    // Clean frame with exact last-sample-to-valid latency.
    t0 = cyc;
    exp_q.push_back('{1'b0, 16'hF065, ev_at(t0, 8, 2*NB+1)});
    send_frame(16'hF065, 8, 1'b0, 2*NB+2, -1);
    hold(LO, 16);
    drain("t1_drain");
    check("t1_data_out", 32'(data_out), 32'h0000F065);

    // Pair 5 forced to 11: error on its second sample, data_out kept.
    t0 = cyc;
    exp_q.push_back('{1'b1, 16'hF065, ev_at(t0, 8, 13)});
    send_frame(16'hF065, 8, 1'b0, 14, 5);
    hold(LO, 24);
    drain("t2_drain");
    check("t2_busy", 32'(busy), 0);

    // Alternating +/-2 cycle chip jitter.
    exp_q.push_back('{1'b0, 16'hF065, -1});
    send_frame(16'hF065, 8, 1'b1, 2*NB+2, -1);
    hold(LO, 16);
    drain("t3_drain");

    // Rising edge after only 5 low cycles is not a start bit.
    enable = 1'b0;
    hold(HI, 2);
    enable = 1'b1;
    hold(HI, 10);
    hold(LO, 5);
    adc_in = HI;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t6_short_quiet_busy", 32'(busy), 0);
    end
    t0 = cyc;
    exp_q.push_back('{1'b0, 16'h1234, ev_at(t0, 8, 2*NB+1)});
    send_frame(16'h1234, 8, 1'b0, 2*NB+2, -1);
    t0 = cyc;
    exp_q.push_back('{1'b0, 16'hFFFF, ev_at(t0, 8, 2*NB+1)});
    send_frame(16'hFFFF, 8, 1'b0, 2*NB+2, -1);
    // Previous frame ends high: only the start chip's CC low cycles separate them.
    t0 = cyc;
    exp_q.push_back('{1'b0, 16'h1234, ev_at(t0, 0, 2*NB+1)});
    send_frame(16'h1234, 0, 1'b0, 2*NB+2, -1);
    hold(LO, 16);
    drain("t6_drain");

    // Enable dropped mid-frame.
    send_frame(16'hA5A5, 8, 1'b0, 20, -1);
    check("t5_busy_mid", 32'(busy), 1);
    enable = 1'b0;
    adc_in = LO;
    step();
    check("t5_en_busy", 32'(busy), 0);
    hold(LO, 10);
    enable = 1'b1;
    hold(LO, 4);

    // Enable dropped in the very cycle the last pair decodes.
    send_frame(16'hA5A5, 8, 1'b0, 2*NB+1, -1);
    hold(HI, 6);
    enable = 1'b0;
    hold(HI, 2);
    check("t5_en_last_busy", 32'(busy), 0);
    hold(LO, 10);
    enable = 1'b1;
    hold(LO, 4);

    // Reset mid-frame clears data_out.
    send_frame(16'hA5A5, 8, 1'b0, 20, -1);
    nrst   = 1'b1;
    adc_in = LO;
    step();
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_data_out", 32'(data_out), 0);
    check("t5_rst_valid", 32'(data_valid), 0);
    nrst = 1'b0;
    hold(LO, 4);

    t0 = cyc;
    exp_q.push_back('{1'b0, 16'hA5A5, ev_at(t0, 8, 2*NB+1)});
    send_frame(16'hA5A5, 8, 1'b0, 2*NB+2, -1);
    hold(LO, 16);
    drain("t5_fresh_drain");
    check("t5_fresh_data_out", 32'(data_out), 32'h0000A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
